// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: single-cycle data-memory responder with a byte-addressable RAM
// and an MMIO page holding LED, timer/compare and status/interrupt registers.
module dmem_mmio_responder #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter int unsigned LED_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_w,
   input  logic [31:0]      Addr_in,
   input  logic [2:0]       DMType,
   input  logic [31:0]      Data_in,
   output logic [31:0]      Data_out,
   output logic [LED_W-1:0] led,
   output logic             irq,
   output logic             misalign_err
);
   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;
   logic [31:0] ram [RAM_WORDS];
   logic [31:0] mtime, mtimecmp, word, mmio_word, wdata;
   logic        pending, enable, err;
   logic        is_ram, is_mmio, is_b, is_h, is_w, mis, st, ram_we, mmio_we, err_set;
   logic        w_led, w_mtime, w_cmp, w_status, match;
   logic [3:0]  be;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   always_comb begin
      is_ram    = {1'b0, Addr_in} < RAM_BYTES;
      is_mmio   = Addr_in[31:4] == MMIO_BASE[31:4];
      is_b      = DMType[1:0] == 2'b00;
      is_h      = DMType[1:0] == 2'b01;
      is_w      = DMType == 3'b010;
      mis       = (is_h & Addr_in[0]) | (is_w & |Addr_in[1:0]);
      word      = is_ram ? ram[Addr_in[AW+1:2]] : 32'd0;
      byte_v    = word[{Addr_in[1:0], 3'b000} +: 8];
      half_v    = Addr_in[1] ? word[31:16] : word[15:0];
      mmio_word = Addr_in[3:2] == 2'd0 ? 32'(led) :
                  Addr_in[3:2] == 2'd1 ? mtime :
                  Addr_in[3:2] == 2'd2 ? mtimecmp : {29'd0, err, enable, pending};
      Data_out  = mis     ? 32'd0 :
                  is_mmio ? (is_w ? mmio_word : 32'd0) :
                  is_w    ? word :
                  is_h    ? {{16{~DMType[2] & half_v[15]}}, half_v} :
                  is_b    ? {{24{~DMType[2] & byte_v[7]}}, byte_v} : 32'd0;
      // only SB/SH/SW are store types; BU/HU and reserved codes never write
      st        = mem_w & ~DMType[2] & (is_b | is_h | is_w);
      ram_we    = st & ~mis & is_ram;
      mmio_we   = st & ~mis & is_mmio & is_w;
      err_set   = st & ((mis & (is_ram | is_mmio)) | (is_mmio & ~is_w));
      w_led     = mmio_we & (Addr_in[3:2] == 2'd0);
      w_mtime   = mmio_we & (Addr_in[3:2] == 2'd1);
      w_cmp     = mmio_we & (Addr_in[3:2] == 2'd2);
      w_status  = mmio_we & (Addr_in[3:2] == 2'd3);
      match     = enable & (mtime == mtimecmp);
      be        = is_w ? 4'hF : is_h ? (Addr_in[1] ? 4'hC : 4'h3) : 4'b0001 << Addr_in[1:0];
      wdata     = is_w ? Data_in : is_h ? {2{Data_in[15:0]}} : {4{Data_in[7:0]}};
      irq          = pending & enable;
      misalign_err = err;
   end
   always_ff @(posedge clk)
      if (ram_we)
         for (int i = 0; i < 4; i++)
            if (be[i]) ram[Addr_in[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
   // status set conditions take priority over same-cycle write-1-to-clear
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         led      <= '0;
         mtime    <= 32'd0;
         mtimecmp <= 32'hFFFF_FFFF;
         pending  <= 1'b0;
         enable   <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (w_led) led <= Data_in[LED_W-1:0];
         mtime <= w_mtime ? Data_in : mtime + 32'd1;
         if (w_cmp) mtimecmp <= Data_in;
         pending <= match | (pending & ~(w_status & Data_in[0]));
         if (w_status) enable <= Data_in[1];
         err <= err_set | (err & ~(w_status & Data_in[2]));
      end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed test-plan steps plus random traffic checked
// against a byte-level memory and register model.
module tb_dmem_mmio_responder;
   localparam logic [31:0] MB = 32'hFFFF_0000;
   localparam int RAM_BYTES = 4096;
   logic        clk = 0, rst = 0, mem_w = 0;
   logic [31:0] Addr_in = 0, Data_in = 0, Data_out;
   logic [2:0]  DMType = 0;
   logic [15:0] led;
   logic        irq, misalign_err;
   int          vectors = 0, miscompares = 0;
   bit [7:0]    m [int];
   bit [31:0]   m_led, m_mtime, m_cmp;
   bit          m_pend, m_en, m_err;
   dmem_mmio_responder dut (
      .clk(clk), .rst(rst), .mem_w(mem_w), .Addr_in(Addr_in), .DMType(DMType),
      .Data_in(Data_in), .Data_out(Data_out), .led(led), .irq(irq), .misalign_err(misalign_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic m_reset();
      m_led = 0; m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_en = 0; m_err = 0;
   endtask
   function automatic bit model_load(input bit [31:0] a, input bit [2:0] t, output bit [31:0] v);
      int sz;
      bit [31:0] r;
      v = 0;
      r = 0;
      sz = (t == 0 || t == 4) ? 1 : (t == 1 || t == 5) ? 2 : (t == 2) ? 4 : 0;
      if (sz == 0 || a % sz != 0) return 1;
      if (a < RAM_BYTES) begin
         for (int k = 0; k < sz; k++) begin
            if (!m.exists(int'(a) + k)) return 0;
            r |= 32'(m[int'(a) + k]) << (8 * k);
         end
         if (t == 0 && r[7]) r |= 32'hFFFF_FF00;
         if (t == 1 && r[15]) r |= 32'hFFFF_0000;
         v = r;
      end else if (a[31:4] == MB[31:4] && sz == 4)
         v = a[3:2] == 0 ? m_led : a[3:2] == 1 ? m_mtime : a[3:2] == 2 ? m_cmp : {29'd0, m_err, m_en, m_pend};
      return 1;
   endfunction
   task automatic model_edge(input bit w, input bit [31:0] a, input bit [2:0] t, input bit [31:0] d);
      int sz = (t == 0) ? 1 : (t == 1) ? 2 : (t == 2) ? 4 : 0;
      bit set_p = m_en && m_mtime == m_cmp;
      bit err_s = 0, clr_p = 0, clr_e = 0;
      m_mtime++;
      if (w && sz != 0) begin
         if (a < RAM_BYTES) begin
            if (a % sz != 0) err_s = 1;
            else for (int k = 0; k < sz; k++) m[int'(a) + k] = d[8*k +: 8];
         end else if (a[31:4] == MB[31:4]) begin
            if (sz != 4 || a[1:0] != 0) err_s = 1;
            else case (a[3:2])
               2'd0: m_led = {16'd0, d[15:0]};
               2'd1: m_mtime = d;
               2'd2: m_cmp = d;
               default: begin m_en = d[1]; clr_p = d[0]; clr_e = d[2]; end
            endcase
         end
      end
      m_pend = set_p | (m_pend & !clr_p);
      m_err = err_s | (m_err & !clr_e);
   endtask
   task automatic drive(input bit w, input bit [31:0] a, input bit [2:0] t, input bit [31:0] d);
      mem_w = w; Addr_in = a; DMType = t; Data_in = d;
   endtask
   task automatic tick();
      bit [31:0] v;
      #2;
      if (model_load(Addr_in, DMType, v)) check($sformatf("load@%h/t%0d", Addr_in, DMType), Data_out, v);
      check("led", 32'(led), m_led);
      check("irq", 32'(irq), 32'(m_pend & m_en));
      check("misalign_err", 32'(misalign_err), 32'(m_err));
      @(posedge clk);
      model_edge(mem_w, Addr_in, DMType, Data_in);
      #1;
   endtask
   task automatic op(input bit w, input bit [31:0] a, input bit [2:0] t, input bit [31:0] d);
      drive(w, a, t, d);
      tick();
   endtask
   task automatic rd(input string tag, input bit [31:0] a, input bit [2:0] t, input bit [31:0] exp);
      drive(0, a, t, 0);
      #1;
      check(tag, Data_out, exp);
   endtask
   initial begin
      bit [31:0] a, d;
      bit [2:0] t;
      m_reset();
      #11 rst = 1;
      for (int i = 0; i < 10; i++) tick();
      rd("mtime_cycle10", MB + 4, 3'd2, 32'd10);
      op(1, MB + 4, 3'd2, 32'hFFFF_FFFE);
      rd("mtime_fffe", MB + 4, 3'd2, 32'hFFFF_FFFE);
      tick();
      rd("mtime_ffff", MB + 4, 3'd2, 32'hFFFF_FFFF);
      tick();
      rd("mtime_wrap0", MB + 4, 3'd2, 32'd0);
      tick();
      op(1, 32'h10, 3'd2, 32'h8765_4321);
      op(1, 32'h11, 3'd0, 32'h1234_56AA);
      rd("lw_10", 32'h10, 3'd2, 32'h8765_AA21);
      rd("lb_11", 32'h11, 3'd0, 32'hFFFF_FFAA);
      rd("lbu_11", 32'h11, 3'd4, 32'h0000_00AA);
      op(1, 32'h20, 3'd2, 32'h1111_2222);
      op(1, 32'h22, 3'd1, 32'h0000_BEEF);
      rd("lh_22", 32'h22, 3'd1, 32'hFFFF_BEEF);
      rd("lhu_22", 32'h22, 3'd5, 32'h0000_BEEF);
      rd("lw_20", 32'h20, 3'd2, 32'hBEEF_2222);
      op(1, 32'h14, 3'd2, 32'h5555_6666);
      op(1, 32'h13, 3'd2, 32'hDEAD_BEEF);
      check("err_after_sw13", 32'(misalign_err), 32'd1);
      op(1, 32'h15, 3'd1, 32'hCAFE_F00D);
      rd("lw_10_kept", 32'h10, 3'd2, 32'h8765_AA21);
      rd("lw_14_kept", 32'h14, 3'd2, 32'h5555_6666);
      op(1, MB + 12, 3'd2, 32'h4);
      check("err_cleared", 32'(misalign_err), 32'd0);
      op(1, MB + 8, 3'd2, 32'd50);
      op(1, MB + 12, 3'd2, 32'h2);
      drive(0, MB + 4, 3'd2, 0);
      for (int i = 0; i < 200 && !irq; i++) tick();
      check("irq_rise", 32'(irq), 32'd1);
      rd("mtime_at_irq", MB + 4, 3'd2, 32'd51);
      op(1, MB + 12, 3'd2, 32'h3);
      check("irq_cleared", 32'(irq), 32'd0);
      op(1, MB + 4, 3'd2, 32'hFFFF_FFC0);
      drive(0, MB + 4, 3'd2, 0);
      for (int i = 0; i < 300 && !irq; i++) tick();
      check("irq_rewrap", 32'(irq), 32'd1);
      rd("mtime_at_irq2", MB + 4, 3'd2, 32'd51);
      op(1, MB, 3'd2, 32'h0000_A5A5);
      check("led_set", 32'(led), 32'h0000_A5A5);
      #1 rst = 0;
      m_reset();
      #1;
      check("rst_led", 32'(led), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_err", 32'(misalign_err), 32'd0);
      rd("rst_mtime", MB + 4, 3'd2, 32'd0);
      rd("rst_cmp", MB + 8, 3'd2, 32'hFFFF_FFFF);
      #1 rst = 1;
      rd("ram_kept", 32'h10, 3'd2, 32'h8765_AA21);
      tick();
      for (int w = 0; w < 16; w++) op(1, 32'(w * 4), 3'd2, $urandom);
      for (int w = 1020; w < 1024; w++) op(1, 32'(w * 4), 3'd2, $urandom);
      for (int i = 0; i < 1500; i++) begin
         int c = $urandom_range(0, 9);
         t = 3'($urandom_range(0, 7));
         d = $urandom;
         if (c <= 5) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         else if (c <= 7) a = MB + 32'($urandom_range(0, 15));
         else if (c == 8) a = ($urandom_range(0, 1) == 1) ? 32'h0000_1000 + 32'($urandom_range(0, 255)) : MB + 32'h10 + 32'($urandom_range(0, 255));
         else a = 32'((1020 + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
         if (a == MB + 8 && $urandom_range(0, 1) == 1) d = m_mtime + 32'($urandom_range(1, 5));
         op(1'($urandom_range(0, 1)), a, t, d);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
